register_file_wb: RTL and testbench

REGISTER_FILE_WB -- requirements
Module: register_file_wb

---
 rtl/register_file_wb.sv | 119 +++++++++++
 tb/tb_register_file_wb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register_file_wb.sv
// register_file_wb: a register file with R0 hardwired to zero and two
// combinational read ports with write bypass. A 64-bit write-back puts the
// low word into DA at edge N and the high word into DA+1 (mod 32) at edge
// N+1, using a one-entry pending slot.
module register_file_wb #(
  parameter int unsigned NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RW,
  input  logic        MW64,
  input  logic [4:0]  DA,
  input  logic [63:0] Bus_D,
  input  logic [4:0]  AA,
  input  logic [4:0]  BA,
  output logic [31:0] A_data,
  output logic [31:0] B_data,
  output logic        wb_busy
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  // Deferred high-word write of a 64-bit write-back.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } hi_slot_t;

  hi_slot_t      pend;
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] hi_addr;
  logic          load_hi;
  logic          bypass_en;
  logic          a_in_range;
  logic          b_in_range;

  // The high-word address wraps naturally in 5 bits, so DA=31 targets R0.
  assign hi_addr   = DA + AW'(1);
  assign load_hi   = RW & MW64;
  // Nothing commits while reset is asserted, so bypass is suppressed then.
  assign bypass_en = ~reset;
  assign a_in_range = (32'(AA) < NREG);
  assign b_in_range = (32'(BA) < NREG);

  // The slot is the registered busy flag: it is high only between edges N and N+1.
  assign wb_busy = pend.valid;

  // Register array update. R0 is never written.
  // A new write takes priority over a retiring high word to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (RW && (DA == AW'(i))) begin
          regs[i] <= Bus_D[DW-1:0];
        end else if (pend.valid && (pend.addr == AW'(i))) begin
          regs[i] <= pend.data;
        end
      end
    end
  end

  // Pending slot. A new 64-bit write reloads the slot at the same edge
  // that the old slot retires, so back-to-back writes lose nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend.valid <= load_hi;
      if (load_hi) begin
        pend.addr <= hi_addr;
        pend.data <= Bus_D[2*DW-1:DW];
      end
    end
  end

  // Read port A. Bypass priority is new low word, then pending high word,
  // then the register array.
  always_comb begin
    A_data = '0;
    if ((AA != '0) && a_in_range) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (AA == AW'(i)) begin
          A_data = regs[i];
        end
      end
      if (bypass_en && pend.valid && (pend.addr == AA)) begin
        A_data = pend.data;
      end
      if (bypass_en && RW && (DA == AA)) begin
        A_data = Bus_D[DW-1:0];
      end
    end
  end

  // Read port B, same bypass priority as port A.
  always_comb begin
    B_data = '0;
    if ((BA != '0) && b_in_range) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (BA == AW'(i)) begin
          B_data = regs[i];
        end
      end
      if (bypass_en && pend.valid && (pend.addr == BA)) begin
        B_data = pend.data;
      end
      if (bypass_en && RW && (DA == BA)) begin
        B_data = Bus_D[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_register_file_wb.sv
// Testbench for register_file_wb. A reference model works out what every
// register holds after the next edge. A read is expected to return that
// next-edge value when no reset is applied, and the current value during
// reset. The bench runs the directed scenarios first and then random traffic.
module tb_register_file_wb;

  logic        clk;
  logic        reset;
  logic        RW;
  logic        MW64;
  logic [4:0]  DA;
  logic [63:0] Bus_D;
  logic [4:0]  AA;
  logic [4:0]  BA;
  logic [31:0] A_data;
  logic [31:0] B_data;
  logic        wb_busy;

  register_file_wb #(.NREG(32)) dut (
    .clk(clk), .reset(reset), .RW(RW), .MW64(MW64), .DA(DA), .Bus_D(Bus_D),
    .AA(AA), .BA(BA), .A_data(A_data), .B_data(B_data), .wb_busy(wb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: current contents and next-edge contents, plus the pending high word.
  logic [31:0] m_cur [32];
  logic [31:0] m_nxt [32];
  logic        m_pv, m_npv;
  int          m_pa, m_npa;
  logic [31:0] m_pd, m_npd;

  // Compare one value and report any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] exp_read(input logic rst, input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    return rst ? m_cur[addr] : m_nxt[addr];
  endfunction

  // Drive one cycle. The previous edge has already happened, so the model
  // first advances to the next-edge state it computed last time.
  task automatic drive_cycle(input logic rst, input logic rw, input logic mw,
                             input logic [4:0] da, input logic [63:0] bus,
                             input logic [4:0] aa, input logic [4:0] ba, input logic chk);
    @(negedge clk);
    m_cur = m_nxt;
    m_pv = m_npv; m_pa = m_npa; m_pd = m_npd;
    reset = rst; RW = rw; MW64 = mw; DA = da; Bus_D = bus; AA = aa; BA = ba;
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_nxt[i] = 32'd0;
      m_npv = 1'b0; m_npa = 0; m_npd = 32'd0;
    end else begin
      m_nxt = m_cur;
      if (m_pv && m_pa != 0) m_nxt[m_pa] = m_pd;
      if (rw && da != 5'd0) m_nxt[da] = bus[31:0];
      m_npv = rw && mw;
      m_npa = (int'(da) + 1) % 32;
      m_npd = bus[63:32];
    end
    if (chk) begin
      check($sformatf("A_data aa=%0d", aa), A_data, exp_read(rst, aa));
      check($sformatf("B_data ba=%0d", ba), B_data, exp_read(rst, ba));
      check("wb_busy", 32'(wb_busy), 32'(m_pv));
    end
  endtask

  logic [4:0]  rda, raa, rba, last_da;
  logic [63:0] rbus;

  initial begin
    for (int i = 0; i < 32; i++) begin m_cur[i] = 32'd0; m_nxt[i] = 32'd0; end
    m_pv = 0; m_npv = 0; m_pa = 0; m_npa = 0; m_pd = 0; m_npd = 0;
    reset = 1; RW = 0; MW64 = 0; DA = 0; Bus_D = 0; AA = 0; BA = 0;

    // Reset, then check that everything reads zero.
    drive_cycle(1, 0, 0, 0, 64'd0, 0, 0, 0);
    drive_cycle(1, 1, 1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 3, 4, 1);
    drive_cycle(0, 0, 0, 0, 64'd0, 5, 31, 1);
    check("reset A", A_data, 32'd0);
    check("reset busy", 32'(wb_busy), 32'd0);

    // Simple 32-bit write with read-back.
    drive_cycle(0, 1, 0, 5, 64'h0000_0000_DEAD_BEEF, 5, 0, 1);
    drive_cycle(0, 0, 0, 0, 64'd0, 5, 0, 1);
    check("s027 A", A_data, 32'hDEAD_BEEF);
    check("s027 busy", 32'(wb_busy), 32'd0);

    // 64-bit write to 6/7.
    drive_cycle(0, 1, 1, 6, 64'h1234_5678_9ABC_DEF0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 64'd0, 6, 7, 1);
    check("s028 reg6", A_data, 32'h9ABC_DEF0);
    check("s028 busy", 32'(wb_busy), 32'd1);
    check("s028 bypass7", B_data, 32'h1234_5678);
    drive_cycle(0, 0, 0, 0, 64'd0, 7, 6, 1);
    check("s028 reg7", A_data, 32'h1234_5678);
    check("s028 busy off", 32'(wb_busy), 32'd0);

    // DA=31: the high word wraps to R0 and is discarded.
    drive_cycle(0, 1, 1, 31, 64'hCAFE_F00D_1357_9BDF, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 64'd0, 31, 0, 1);
    check("s029 reg31", A_data, 32'h1357_9BDF);
    check("s029 reg0", B_data, 32'd0);
    check("s029 busy", 32'(wb_busy), 32'd1);
    drive_cycle(0, 0, 0, 0, 64'd0, 0, 31, 1);
    check("s029 reg0 after", A_data, 32'd0);
    check("s029 busy off", 32'(wb_busy), 32'd0);

    // A new write to 7 overrides the retiring pending high word.
    drive_cycle(0, 1, 1, 6, 64'h5555_5555_6666_6666, 0, 0, 1);
    drive_cycle(0, 1, 0, 7, 64'hBBBB_BBBB_AAAA_0000, 0, 7, 1);
    check("s030 bypass", B_data, 32'hAAAA_0000);
    drive_cycle(0, 0, 0, 0, 64'd0, 7, 6, 1);
    check("s030 reg7", A_data, 32'hAAAA_0000);
    check("s030 reg6", B_data, 32'h6666_6666);

    // Back-to-back 64-bit writes.
    drive_cycle(0, 1, 1, 2, 64'h3333_3333_2222_2222, 0, 0, 1);
    drive_cycle(0, 1, 1, 4, 64'h5555_AAAA_4444_BBBB, 3, 0, 1);
    check("s031 busy1", 32'(wb_busy), 32'd1);
    drive_cycle(0, 0, 0, 0, 64'd0, 2, 3, 1);
    check("s031 busy2", 32'(wb_busy), 32'd1);
    check("s031 reg2", A_data, 32'h2222_2222);
    check("s031 reg3", B_data, 32'h3333_3333);
    drive_cycle(0, 0, 0, 0, 64'd0, 4, 5, 1);
    check("s031 reg4", A_data, 32'h4444_BBBB);
    check("s031 reg5", B_data, 32'h5555_AAAA);
    check("s031 busy off", 32'(wb_busy), 32'd0);

    // Reset while the high word is pending.
    drive_cycle(0, 1, 1, 10, 64'h0BAD_0BAD_0A0A_0A0A, 0, 0, 1);
    drive_cycle(1, 0, 0, 0, 64'd0, 10, 11, 1);
    check("s032 busy at reset", 32'(wb_busy), 32'd1);
    drive_cycle(0, 0, 0, 0, 64'd0, 10, 11, 1);
    check("s032 reg10", A_data, 32'd0);
    check("s032 reg11", B_data, 32'd0);
    check("s032 busy", 32'(wb_busy), 32'd0);

    // Random traffic. Read addresses often target the last or current write.
    last_da = 5'd1;
    for (int c = 0; c < 1500; c++) begin
      rda  = 5'($urandom_range(0, 31));
      rbus = {32'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0: raa = last_da;
        1: raa = rda;
        default: raa = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
        0: rba = last_da + 5'd1;
        1: rba = rda;
        default: rba = 5'($urandom_range(0, 31));
      endcase
      drive_cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rda, rbus, raa, rba, 1);
      last_da = rda;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
